// File: rtl/if_fetch_queue_pkg.sv
// Shared types and defaults for the instruction-fetch stage and its prefetch queue.
package fetch_pkg;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] INCR_DEFAULT     = 32'd4;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request/response port between the fetch stage (master) and IM/cache (slave).
interface if_fetch_queue_if;
   logic [31:0] Instr_address_2IM;
   logic        Instr_req_2IM;
   logic        IM_ready;
   logic [31:0] Instr1_fIM;
   logic        Instr_valid_fIM;

   modport master (
      output Instr_address_2IM,
      output Instr_req_2IM,
      input  IM_ready,
      input  Instr1_fIM,
      input  Instr_valid_fIM
   );

   modport slave (
      input  Instr_address_2IM,
      input  Instr_req_2IM,
      output IM_ready,
      output Instr1_fIM,
      output Instr_valid_fIM
   );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO with flush; simultaneous push and pop are legal even when full.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) mem_q <= mem_d;

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (count_q == '0);
   assign full  = (32'(count_q) == 32'(DEPTH));
   assign count = count_q;
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC generator, credit-limited pipelined IM requests, prefetch queue and ID output register.
// Optional IF_BYPASS_EN: a response arriving with the queue empty loads the output register directly.
module if_fetch_queue
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] INCR            = INCR_DEFAULT
) (
   input  logic                CLK,
   input  logic                RESET,
   if_fetch_queue_if.master    im,
   input  logic                STALL,
   input  logic                Request_Alt_PC,
   input  logic [31:0]         Alt_PC,
   output logic [31:0]         Instr1_OUT,
   output logic [31:0]         Instr_PC_OUT,
   output logic [31:0]         Instr_PC_Plus4,
   output logic                Instr_valid_OUT
);
   localparam int QCW = $clog2(DEPTH) + 1;
   localparam int TCW = $clog2(MAX_OUTSTANDING) + 1;

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [TCW-1:0] drop_q, drop_d;
   logic [31:0]  instr_out_q, instr_out_d, pc_out_q, pc_out_d, plus4_q, plus4_d;
   logic         valid_out_q, valid_out_d;

   logic         q_push, q_pop, q_full, q_empty;
   logic [QCW-1:0] q_count;
   fetch_entry_t q_din, q_dout;

   logic         t_push, t_pop, t_full, t_empty;
   logic [TCW-1:0] t_count;
   logic [31:0]  t_dout;

   logic         redirect, resp, resp_keep, take_direct, req, issue;

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_queue (
      .clk(CLK), .rst(RESET), .flush(redirect), .push(q_push), .din(q_din), .pop(q_pop),
      .dout(q_dout), .full(q_full), .empty(q_empty), .count(q_count)
   );

   // PC tags of in-flight requests; dropped responses still retire their tag.
   fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(32)) u_tags (
      .clk(CLK), .rst(RESET), .flush(1'b0), .push(t_push), .din(fetch_pc_q), .pop(t_pop),
      .dout(t_dout), .full(t_full), .empty(t_empty), .count(t_count)
   );

   always_comb begin
      redirect  = Request_Alt_PC;
      resp      = im.Instr_valid_fIM && !t_empty;
      resp_keep = resp && (drop_q == '0);
      // Credit: queued plus in-flight never exceeds DEPTH, so a push always has room.
      req       = !RESET && !redirect && !t_full && !q_full
                  && ((32'(q_count) + 32'(t_count)) < 32'(DEPTH));
      issue     = req && im.IM_ready;
      t_push    = issue;
      t_pop     = resp;
      q_din     = '{instr: im.Instr1_fIM, pc: t_dout};
`ifdef IF_BYPASS_EN
      take_direct = resp_keep && q_empty && !STALL && !redirect;
`else
      take_direct = 1'b0;
`endif
      q_push    = resp_keep && !redirect && !take_direct;
      q_pop     = !redirect && !STALL && !q_empty;

      fetch_pc_d = fetch_pc_q;
      if (redirect)   fetch_pc_d = Alt_PC;
      else if (issue) fetch_pc_d = fetch_pc_q + INCR;

      drop_d = drop_q;
      if (redirect)                    drop_d = t_count - TCW'(resp);
      else if (resp && drop_q != '0)   drop_d = drop_q - TCW'(1);

      instr_out_d = instr_out_q;
      pc_out_d    = pc_out_q;
      plus4_d     = plus4_q;
      valid_out_d = valid_out_q;
      if (redirect) begin
         instr_out_d = NOP;
         pc_out_d    = '0;
         plus4_d     = Alt_PC;
         valid_out_d = 1'b0;
      end else if (!STALL) begin
         if (take_direct) begin
            instr_out_d = q_din.instr;
            pc_out_d    = q_din.pc;
            plus4_d     = q_din.pc + INCR;
            valid_out_d = 1'b1;
         end else if (!q_empty) begin
            instr_out_d = q_dout.instr;
            pc_out_d    = q_dout.pc;
            plus4_d     = q_dout.pc + INCR;
            valid_out_d = 1'b1;
         end else begin
            // Bubble keeps Plus4 pointing at the next expected PC.
            instr_out_d = NOP;
            pc_out_d    = '0;
            valid_out_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_pc_q  <= RESET_PC;
         drop_q      <= '0;
         instr_out_q <= NOP;
         pc_out_q    <= '0;
         plus4_q     <= RESET_PC;
         valid_out_q <= 1'b0;
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         drop_q      <= drop_d;
         instr_out_q <= instr_out_d;
         pc_out_q    <= pc_out_d;
         plus4_q     <= plus4_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign im.Instr_req_2IM     = req;
   assign im.Instr_address_2IM = fetch_pc_q;
   assign Instr1_OUT           = instr_out_q;
   assign Instr_PC_OUT         = pc_out_q;
   assign Instr_PC_Plus4       = plus4_q;
   assign Instr_valid_OUT      = valid_out_q;
endmodule
